cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Parametrised run controller between the top-level Start/Ack handshake and the CPU core.
- On a Start handshake it selects one of NUM_PROGS programs, loads that program's base PC, and enables the core until Halt.
- It reports completion on Ack, with a cycle count and fault code.
- Adds multi-program dispatch, a cycle counter and watchdog timeout on top of the single-program Start/Ack flow.

Parameters:
- PC_W, 10, program counter width.
- NUM_PROGS, 3, number of selectable programs (1..2**SEL_W).
- SEL_W, 2, width of ProgSel.
- PROG_BASE, {10'd256,10'd128,10'd0}, packed NUM_PROGS*PC_W base-address table; program i at bits [i*PC_W +: PC_W].
- CYC_W, 16, cycle counter width.
- TIMEOUT_CYC, 0, watchdog limit in run cycles; 0 disables the watchdog.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  host launch handshake (level).
- ProgSel  in  SEL_W  program index, sampled at launch.
- Halt  in  1  core halt indication.
- PcLoad  out  1  one-cycle strobe: core loads PcInit into PC.
- PcInit  out  PC_W  base PC of the selected program.
- Run  out  1  core execute enable.
- Ack  out  1  program finished; held until the next Start rise.
- Busy  out  1  high in LOAD or RUN.
- CycleCount  out  CYC_W  run cycles of the last or current program.
- Fault  out  2  00 ok, 01 watchdog timeout, 10 bad ProgSel.

Behaviour:
- Reset (async, any state, mid-run included):
  - state=IDLE, Start_q=0.
  - PcLoad=0, PcInit=0, Run=0, Ack=0, Busy=0, CycleCount=0, Fault=00.
- Start_q registers Start every edge.
- Launch = edge with Start_q=1 and Start=0 (falling handshake), legal only in IDLE or DONE; ignored in LOAD/RUN.
- Start rise (Start_q=0, Start=1) in DONE clears Ack next cycle; state stays DONE.
- States are IDLE, LOAD, RUN, DONE. Run and Busy are decoded from the registered state.
- On launch:
  - CycleCount and Fault are cleared. ProgSel is latched.
  - If ProgSel >= NUM_PROGS: go to DONE with Fault=10, Ack=1, no PcLoad.
  - Otherwise: PcInit=PROG_BASE[sel], go to LOAD.
- LOAD: PcLoad=1 for exactly this one cycle; Halt is ignored; next state is RUN.
- RUN: Run=1. Each edge in RUN increments CycleCount, saturating at all-ones and never wrapping. The edge that samples Halt is counted.
  - Halt=1 at an edge: go to DONE, Ack=1 from the next cycle, Fault=00.
  - TIMEOUT_CYC!=0, incremented count == TIMEOUT_CYC and Halt=0: go to DONE, Fault=01, Ack=1.
  - Halt and timeout on the same edge: Halt wins, Fault=00.
- DONE: Run=0; Ack, CycleCount and Fault hold until the next launch or Reset.
- Latency:
  - Start fall at edge N: PcLoad high during cycle N..N+1; Run high from edge N+1.
  - Halt at edge M: Run low and Ack high after edge M.
  - Minimum CycleCount is 1.
- Relaunch directly from DONE is permitted. Ack is cleared by the Start rise or by the launch edge, whichever comes first.

Optional Feature:
- Macro CPU_RUN_CTRL_STEP_EN.
- Defined:
  - Adds inputs StepMode (1) and Step (1).
  - In RUN with StepMode=1, Run is high for exactly one cycle per rising edge of Step (edge-detected internally).
  - CycleCount increments only on cycles where Run=1.
  - Halt and timeout are evaluated only on Run=1 cycles.
  - StepMode=0 behaves as undefined.
- Undefined: StepMode and Step ports are absent; Run is continuous in RUN.

Test Plan:
- Reset=1 for 2 cycles, then Reset=0: all outputs 0, state IDLE; a Halt pulse produces no Ack.
- Start 1→0 with ProgSel=1, Halt after 5 run cycles:
  - PcLoad one cycle with PcInit=128, Run high 5 cycles.
  - CycleCount=5, Ack=1, Fault=00.
- ProgSel=3 (NUM_PROGS=3) launch: Ack=1 next cycle, Fault=10, PcLoad never high, CycleCount=0.
- TIMEOUT_CYC=8, Halt never asserted: Run high 8 cycles, then Ack=1, Fault=01, CycleCount=8.
- Reset asserted in RUN cycle 3: Run/Busy drop immediately (async); the following launch with ProgSel=2 loads PcInit=256 cleanly.
- Relaunch from DONE:
  - Start rise clears Ack; Start fall with ProgSel=0 gives PcInit=0 and CycleCount restarting from 1.
  - Start toggles during RUN are ignored.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run controller: Start-fall launches program ProgSel (LOAD 1 cycle, then RUN until Halt/watchdog), Ack on finish.
// Optional single-step gating of Run when CPU_RUN_CTRL_STEP_EN is defined; no backpressure, Start is a level handshake.
module cpu_run_ctrl #(
  parameter int PC_W        = 10,
  parameter int NUM_PROGS   = 3,
  parameter int SEL_W       = 2,
  parameter logic [NUM_PROGS*PC_W-1:0] PROG_BASE = {10'd256, 10'd128, 10'd0},
  parameter int CYC_W       = 16,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [SEL_W-1:0] ProgSel,
  input  logic             Halt,
`ifdef CPU_RUN_CTRL_STEP_EN
  input  logic             StepMode,
  input  logic             Step,
`endif
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcInit,
  output logic             Run,
  output logic             Ack,
  output logic             Busy,
  output logic [CYC_W-1:0] CycleCount,
  output logic [1:0]       Fault
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic               start_q;
  logic [PC_W-1:0]    pc_init_q, pc_init_d;
  logic               ack_q, ack_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [1:0]         fault_q, fault_d;

  logic               launch, start_rise, run_act, prog_ok;
  logic [PC_W-1:0]    base;
  logic [CYC_W-1:0]   cnt_inc;

`ifdef CPU_RUN_CTRL_STEP_EN
  logic step_q, step_fire_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      step_q      <= 1'b0;
      step_fire_q <= 1'b0;
    end else begin
      step_q      <= Step;
      step_fire_q <= Step & ~step_q;
    end
  end

  assign run_act = (state_q == RUN) && (!StepMode || step_fire_q);
`else
  assign run_act = (state_q == RUN);
`endif

  assign launch     = start_q & ~Start & ((state_q == IDLE) || (state_q == DONE));
  assign start_rise = ~start_q & Start;
  // Count saturates at all-ones rather than wrapping.
  assign cnt_inc    = (&cyc_q) ? cyc_q : cyc_q + 1'b1;

  always_comb begin
    base    = '0;
    prog_ok = 1'b0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (ProgSel == SEL_W'(i)) begin
        base    = PROG_BASE[i*PC_W +: PC_W];
        prog_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_init_d = pc_init_q;
    ack_d     = ack_q;
    cyc_d     = cyc_q;
    fault_d   = fault_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && start_rise) ack_d = 1'b0;
        if (launch) begin
          cyc_d   = '0;
          fault_d = 2'b00;
          ack_d   = 1'b0;
          if (prog_ok) begin
            pc_init_d = base;
            state_d   = LOAD;
          end else begin
            state_d = DONE;
            fault_d = 2'b10;
            ack_d   = 1'b1;
          end
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (run_act) begin
          cyc_d = cnt_inc;
          // Halt takes priority over a watchdog expiring on the same edge.
          if (Halt) begin
            state_d = DONE;
            ack_d   = 1'b1;
            fault_d = 2'b00;
          end else if (TIMEOUT_CYC != 0 && cnt_inc == CYC_W'(TIMEOUT_CYC)) begin
            state_d = DONE;
            ack_d   = 1'b1;
            fault_d = 2'b01;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      pc_init_q <= '0;
      ack_q     <= 1'b0;
      cyc_q     <= '0;
      fault_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      start_q   <= Start;
      pc_init_q <= pc_init_d;
      ack_q     <= ack_d;
      cyc_q     <= cyc_d;
      fault_q   <= fault_d;
    end
  end

  assign PcLoad     = (state_q == LOAD);
  assign PcInit     = pc_init_q;
  assign Run        = run_act;
  assign Ack        = ack_q;
  assign Busy       = (state_q == LOAD) || (state_q == RUN);
  assign CycleCount = cyc_q;
  assign Fault      = fault_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed table-driven bench for cpu_run_ctrl built with an 8-cycle watchdog.
module tb_cpu_run_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  ProgSel;
  logic        Halt;
  logic        PcLoad;
  logic [9:0]  PcInit;
  logic        Run;
  logic        Ack;
  logic        Busy;
  logic [15:0] CycleCount;
  logic [1:0]  Fault;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  cpu_run_ctrl #(
    .PC_W(10), .NUM_PROGS(3), .SEL_W(2),
    .PROG_BASE({10'd256, 10'd128, 10'd0}),
    .CYC_W(16), .TIMEOUT_CYC(8)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Halt(Halt),
`ifdef CPU_RUN_CTRL_STEP_EN
    .StepMode(1'b0), .Step(1'b0),
`endif
    .PcLoad(PcLoad), .PcInit(PcInit), .Run(Run), .Ack(Ack), .Busy(Busy),
    .CycleCount(CycleCount), .Fault(Fault)
  );

  typedef struct packed {
    logic        pcload;
    logic [9:0]  pcinit;
    logic        run;
    logic        ack;
    logic        busy;
    logic [15:0] cnt;
    logic [1:0]  fault;
  } obs_t;

  typedef struct {
    logic       start;
    logic [1:0] sel;
    logic       halt;
    obs_t       exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  function automatic obs_t sample();
    obs_t o;
    o.pcload = PcLoad; o.pcinit = PcInit; o.run = Run; o.ack = Ack;
    o.busy = Busy; o.cnt = CycleCount; o.fault = Fault;
    return o;
  endfunction

  function automatic obs_t mk(logic pl, logic [9:0] pi, logic r, logic a, logic b,
                              logic [15:0] c, logic [1:0] f);
    obs_t o;
    o.pcload = pl; o.pcinit = pi; o.run = r; o.ack = a; o.busy = b; o.cnt = c; o.fault = f;
    return o;
  endfunction

  task automatic add(string nm, logic s, logic [1:0] sel, logic h, obs_t e);
    vec_t v;
    v.start = s; v.sel = sel; v.halt = h; v.exp = e; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic chk(string nm, obs_t got, obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got pcload=%0b pcinit=%0d run=%0b ack=%0b busy=%0b cnt=%0d fault=%b ; want pcload=%0b pcinit=%0d run=%0b ack=%0b busy=%0b cnt=%0d fault=%b",
               nm, got.pcload, got.pcinit, got.run, got.ack, got.busy, got.cnt, got.fault,
               exp.pcload, exp.pcinit, exp.run, exp.ack, exp.busy, exp.cnt, exp.fault);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    bit got_ack;

    // inputs per edge, then expected outputs just after that edge
    add("idle_halt",    1'b0, 2'd0, 1'b1, mk(0,   0, 0, 0, 0, 0, 2'b00));
    add("arm_p1",       1'b1, 2'd1, 1'b0, mk(0,   0, 0, 0, 0, 0, 2'b00));
    add("launch_p1",    1'b0, 2'd1, 1'b0, mk(1, 128, 0, 0, 1, 0, 2'b00));
    add("load_halt_ig", 1'b0, 2'd1, 1'b1, mk(0, 128, 1, 0, 1, 0, 2'b00));
    add("run_c1",       1'b0, 2'd1, 1'b0, mk(0, 128, 1, 0, 1, 1, 2'b00));
    add("run_c2",       1'b0, 2'd1, 1'b0, mk(0, 128, 1, 0, 1, 2, 2'b00));
    add("run_c3",       1'b0, 2'd1, 1'b0, mk(0, 128, 1, 0, 1, 3, 2'b00));
    add("run_c4",       1'b0, 2'd1, 1'b0, mk(0, 128, 1, 0, 1, 4, 2'b00));
    add("halt_p1",      1'b0, 2'd1, 1'b1, mk(0, 128, 0, 1, 0, 5, 2'b00));
    add("rise_clr_ack", 1'b1, 2'd1, 1'b0, mk(0, 128, 0, 0, 0, 5, 2'b00));
    add("bad_sel",      1'b0, 2'd3, 1'b0, mk(0, 128, 0, 1, 0, 0, 2'b10));
    add("rise_clr_bad", 1'b1, 2'd3, 1'b0, mk(0, 128, 0, 0, 0, 0, 2'b10));
    add("launch_p2",    1'b0, 2'd2, 1'b0, mk(1, 256, 0, 0, 1, 0, 2'b00));
    add("wd_c0",        1'b0, 2'd2, 1'b0, mk(0, 256, 1, 0, 1, 0, 2'b00));
    add("wd_c1",        1'b0, 2'd2, 1'b0, mk(0, 256, 1, 0, 1, 1, 2'b00));
    add("wd_rise_ign",  1'b1, 2'd0, 1'b0, mk(0, 256, 1, 0, 1, 2, 2'b00));
    add("wd_fall_ign",  1'b0, 2'd0, 1'b0, mk(0, 256, 1, 0, 1, 3, 2'b00));
    add("wd_c4",        1'b0, 2'd0, 1'b0, mk(0, 256, 1, 0, 1, 4, 2'b00));
    add("wd_c5",        1'b0, 2'd0, 1'b0, mk(0, 256, 1, 0, 1, 5, 2'b00));
    add("wd_c6",        1'b0, 2'd0, 1'b0, mk(0, 256, 1, 0, 1, 6, 2'b00));
    add("wd_c7",        1'b0, 2'd0, 1'b0, mk(0, 256, 1, 0, 1, 7, 2'b00));
    add("wd_expire",    1'b0, 2'd0, 1'b0, mk(0, 256, 0, 1, 0, 8, 2'b01));
    add("rise_clr_wd",  1'b1, 2'd0, 1'b0, mk(0, 256, 0, 0, 0, 8, 2'b01));
    add("relaunch_p0",  1'b0, 2'd0, 1'b0, mk(1,   0, 0, 0, 1, 0, 2'b00));
    add("p0_run",       1'b0, 2'd0, 1'b0, mk(0,   0, 1, 0, 1, 0, 2'b00));
    add("p0_halt_min",  1'b0, 2'd0, 1'b1, mk(0,   0, 0, 1, 0, 1, 2'b00));

    Reset = 1'b1; Start = 1'b0; ProgSel = 2'd0; Halt = 1'b0;
    repeat (2) tick();
    chk("reset_state", sample(), mk(0, 0, 0, 0, 0, 0, 2'b00));
    Reset = 1'b0;

    foreach (tbl[i]) begin
      Start = tbl[i].start; ProgSel = tbl[i].sel; Halt = tbl[i].halt;
      tick();
      chk(tbl[i].name, sample(), tbl[i].exp);
    end
    Halt = 1'b0;

    // Asynchronous reset in the third run cycle
    Start = 1'b1; tick();
    Start = 1'b0; ProgSel = 2'd1; tick();
    repeat (3) tick();
    chk("pre_areset_run", sample(), mk(0, 128, 1, 0, 1, 2, 2'b00));
    #3 Reset = 1'b1;
    #1 chk("async_reset", sample(), mk(0, 0, 0, 0, 0, 0, 2'b00));
    tick();
    Reset = 1'b0;
    Start = 1'b1; tick();
    Start = 1'b0; ProgSel = 2'd2; tick();
    chk("post_reset_load", sample(), mk(1, 256, 0, 0, 1, 0, 2'b00));

    // Bounded wait for the watchdog to finish the run
    got_ack = 1'b0;
    for (int n = 0; n < 20 && !got_ack; n++) begin
      tick();
      got_ack = Ack;
    end
    checks++;
    if (!got_ack) begin
      errors++;
      $display("FAIL post_reset_ack_wait: Ack=%0b after 20 cycles, want 1", Ack);
    end
    chk("post_reset_timeout", sample(), mk(0, 256, 0, 1, 0, 8, 2'b01));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
